sccb_init_sequencer: RTL and testbench
======================================

// Module: sccb_init_sequencer
// PURPOSE
//   Camera register-init sequencer sitting directly upstream of the SCCB master in sccb_design.
//   Walks an external register table of {reg,data} entries and issues one SCCB write per entry.
//   Supports end and delay marker entries, bounded retry on NACK, and done/error status for the LEDs.
// PARAMETERS
//   AW          5         table address width (max 2**AW entries)
//   DEV_ADDR    8'h42     8-bit SCCB write device ID (OV7670)
//   DELAY_UNIT  50000     clk cycles per delay tick (1 ms at 50 MHz)
//   MAX_RETRY   3         re-issues of a NACKed write before ERROR (0..15)
// PORTS
//   clk            in   1   system clock
//   reset          in   1   async, active-high
//   start          in   1   1-cycle pulse: begin sequence from entry 0
//   rom_addr       out  AW  table index
//   rom_data       in   16  {reg[15:8],data[7:0]}, valid 1 cycle after rom_addr
//   sccb_req       out  1   write request to SCCB master
//   sccb_ready     in   1   master accepts request when sccb_req&&sccb_ready
//   sccb_dev       out  8   = DEV_ADDR
//   sccb_reg       out  8   register address, stable while sccb_req
//   sccb_data      out  8   register data, stable while sccb_req
//   sccb_done      in   1   1-cycle pulse: transaction finished
//   sccb_nack      in   1   qualifies sccb_done: 1 = NACK/failure
//   busy           out  1   sequence in progress
//   cfg_done       out  1   sticky: table completed without error (drives led1)
//   cfg_err        out  1   sticky: retry budget exhausted (drives led2)
// BEHAVIOUR
//   Reset (async): state IDLE, rom_addr=0, sccb_req=0, sccb_reg/data=0, busy=0, cfg_done=0, cfg_err=0.
//   States: IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, FINISH, ERROR.
//   IDLE: start -> FETCH, rom_addr=0, cfg_done/cfg_err cleared, retry count=0. busy=1 in all states except IDLE.
//   FETCH: one wait cycle for ROM latency -> DECODE.
//   DECODE on rom_data:
//     16'hFFFF          -> FINISH (end marker).
//     reg==8'hFE        -> DELAY, load counter = data*DELAY_UNIT; data==0 -> next entry immediately.
//     otherwise         -> latch reg/data, ISSUE.
//   ISSUE: sccb_req=1, reg/data held; on sccb_req&&sccb_ready (same cycle) -> WAIT, req drops next cycle.
//   WAIT: on sccb_done: nack=0 -> next entry, retry count=0; nack=1 and count<MAX_RETRY -> count++, ISSUE
//     (same reg/data); nack=1 and count==MAX_RETRY -> ERROR.
//   Next entry: rom_addr+1 -> FETCH; if rom_addr==2**AW-1 (no wrap) -> FINISH instead.
//   DELAY: decrement each clk; at 0 -> next entry. Delay width sized for 255*DELAY_UNIT.
//   FINISH: cfg_done=1 -> IDLE. ERROR: cfg_err=1 -> IDLE. Flags stay set until next start or reset.
//   start while busy: ignored. sccb_done outside WAIT: ignored. sccb_ready outside ISSUE: ignored.
//   Reset mid-sequence (incl. during ISSUE/WAIT): immediately IDLE, sccb_req=0; no partial resume.
//   Min latency start->first sccb_req: 3 clk (FETCH, DECODE, ISSUE).
// TESTING
//   T1 table {12_80, FE_01, 11_01, FFFF}, DELAY_UNIT=10, ready=1, done 5 clk after accept, nack=0
//      -> writes (12,80) then (11,01); >=10 clk gap after first done; cfg_done=1, cfg_err=0, busy=0.
//   T2 hold sccb_ready=0 for 20 clk in ISSUE -> sccb_req, sccb_reg, sccb_data stable all 20 clk; one accept only.
//   T3 MAX_RETRY=3, entry (3A,04) NACKs 2x then ACKs -> exactly 3 requests of (3A,04); sequence continues; cfg_done=1.
//   T4 entry always NACKs -> exactly 4 requests (1+3); cfg_err=1, cfg_done=0, busy=0, no further rom fetch.
//   T5 AW=2, table without FFFF (4 writes) -> 4 writes, rom_addr stops at 3, cfg_done=1; no wrap to entry 0.
//   T6 assert reset during WAIT; pulse start after release -> sccb_req=0 during reset; restarts at rom_addr=0.

Source files
------------

// File: rtl/sccb_init_sequencer.sv
// -----------------------------------------------------------------------------
// sccb_init_sequencer
//   Camera register-init sequencer placed in front of the SCCB master. It walks
//   an external {reg,data} table and issues one SCCB write per entry. It also
//   handles end and delay marker entries, bounded retry on NACK, and sticky
//   done/error status flags.
//
//   Table entry encoding (rom_data):
//     16'hFFFF        end of table
//     {8'hFE, n}      wait n*DELAY_UNIT clocks (n == 0: skip the entry)
//     {reg, data}     SCCB write of data to register reg
//
// Ports
//   clk         in   1    system clock
//   reset       in   1    asynchronous, active-high
//   start       in   1    1-cycle pulse; starts at entry 0 (ignored while busy)
//   rom_addr    out  AW   table index
//   rom_data    in   16   table entry, valid 1 cycle after rom_addr
//   sccb_req    out  1    write request to the SCCB master
//   sccb_ready  in   1    master accepts when sccb_req && sccb_ready
//   sccb_dev    out  8    device ID (DEV_ADDR)
//   sccb_reg    out  8    register address, held while sccb_req
//   sccb_data   out  8    register data, held while sccb_req
//   sccb_done   in   1    1-cycle pulse: transaction finished
//   sccb_nack   in   1    qualifies sccb_done: 1 = NACK/failure
//   busy        out  1    sequence in progress
//   cfg_done    out  1    sticky: table finished without error
//   cfg_err     out  1    sticky: retry budget exhausted
// -----------------------------------------------------------------------------
module sccb_init_sequencer #(
    parameter int          AW         = 5,
    parameter logic [7:0]  DEV_ADDR   = 8'h42,
    parameter int          DELAY_UNIT = 50000,
    parameter int          MAX_RETRY  = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] rom_addr,
    input  logic [15:0]   rom_data,
    output logic          sccb_req,
    input  logic          sccb_ready,
    output logic [7:0]    sccb_dev,
    output logic [7:0]    sccb_reg,
    output logic [7:0]    sccb_data,
    input  logic          sccb_done,
    input  logic          sccb_nack,
    output logic          busy,
    output logic          cfg_done,
    output logic          cfg_err
);

    // Delay counter must hold the largest marker value, 255 ticks.
    localparam int              DW        = $clog2(255 * DELAY_UNIT + 1);
    localparam logic [DW-1:0]   DUNIT     = DW'(DELAY_UNIT);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRY);
    localparam logic [AW-1:0]   LAST_ADDR = {AW{1'b1}};
    localparam logic [15:0]     END_MARK  = 16'hFFFF;
    localparam logic [7:0]      DLY_MARK  = 8'hFE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_FINISH,
        S_ERROR
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_reg;
    logic [7:0]      r_data;
    logic [DW-1:0]   r_delay;
    logic [3:0]      r_retry;
    logic            r_done;
    logic            r_err;

    state_t          w_state_nxt;
    logic [AW-1:0]   w_addr_nxt;
    logic [7:0]      w_reg_nxt;
    logic [7:0]      w_data_nxt;
    logic [DW-1:0]   w_delay_nxt;
    logic [3:0]      w_retry_nxt;
    logic            w_done_nxt;
    logic            w_err_nxt;
    logic            w_advance;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order-dependent
    // simulation and a mismatch with synthesis.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_reg   <= '0;
            r_data  <= '0;
            r_delay <= '0;
            r_retry <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_reg   <= w_reg_nxt;
            r_data  <= w_data_nxt;
            r_delay <= w_delay_nxt;
            r_retry <= w_retry_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // NOTE: every signal written below gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_reg_nxt   = r_reg;
        w_data_nxt  = r_data;
        w_delay_nxt = r_delay;
        w_retry_nxt = r_retry;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        w_advance   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                    w_addr_nxt  = '0;
                    w_retry_nxt = '0;
                    w_done_nxt  = 1'b0;
                    w_err_nxt   = 1'b0;
                end
            end

            // rom_addr has been stable for one cycle; rom_data is valid next.
            S_FETCH: w_state_nxt = S_DECODE;

            S_DECODE: begin
                if (rom_data == END_MARK) begin
                    w_state_nxt = S_FINISH;
                end else if (rom_data[15:8] == DLY_MARK) begin
                    if (rom_data[7:0] == 8'h00) begin
                        w_advance = 1'b1;
                    end else begin
                        w_delay_nxt = DW'(rom_data[7:0]) * DUNIT;
                        w_state_nxt = S_DELAY;
                    end
                end else begin
                    w_reg_nxt   = rom_data[15:8];
                    w_data_nxt  = rom_data[7:0];
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (sccb_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (sccb_done) begin
                    if (!sccb_nack) begin
                        w_retry_nxt = '0;
                        w_advance   = 1'b1;
                    end else if (r_retry < RETRY_MAX) begin
                        // Re-issue the same reg/data, which are still latched.
                        w_retry_nxt = r_retry + 4'd1;
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_state_nxt = S_ERROR;
                    end
                end
            end

            // Loaded with n*DELAY_UNIT; leaves as the count reaches zero, so
            // the state is held for exactly that many cycles.
            S_DELAY: begin
                w_delay_nxt = r_delay - DW'(1);
                if (r_delay <= DW'(1)) begin
                    w_advance = 1'b1;
                end
            end

            S_FINISH: begin
                w_done_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end

            S_ERROR: begin
                w_err_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: w_state_nxt = S_IDLE;
        endcase

        // Step to the next entry; the last table slot ends the sequence
        // rather than wrapping back to entry 0.
        if (w_advance) begin
            if (r_addr == LAST_ADDR) begin
                w_state_nxt = S_FINISH;
            end else begin
                w_addr_nxt  = r_addr + AW'(1);
                w_state_nxt = S_FETCH;
            end
        end
    end

    // Request is a pure state decode: it drops the cycle after acceptance
    // and is low whenever reset forces IDLE.
    assign sccb_req  = (r_state == S_ISSUE);
    assign sccb_dev  = DEV_ADDR;
    assign sccb_reg  = r_reg;
    assign sccb_data = r_data;
    assign rom_addr  = r_addr;
    assign busy      = (r_state != S_IDLE);
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;

endmodule

// File: tb/tb_sccb_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sccb_init_sequencer
//   Directed bench for sccb_init_sequencer. Instance A (AW=5, DELAY_UNIT=10)
//   covers the table walk, delay, stall, retry, error and reset cases;
//   instance B (AW=2) covers the table-end-without-marker case. A shared
//   SCCB master model serves whichever instance is selected.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sccb_init_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_a, start_b;
    logic        sccb_ready;
    logic        sccb_done, sccb_nack;
    logic        sel;

    logic [4:0]  rom_addr_a;
    logic [1:0]  rom_addr_b;
    logic [15:0] rom_data_a, rom_data_b;
    logic        req_a, req_b, busy_a, busy_b;
    logic        cdone_a, cdone_b, cerr_a, cerr_b;
    logic [7:0]  dev_a, dev_b, reg_a, reg_b, data_a, data_b;

    logic [15:0] rom_a_mem [32];
    logic [15:0] rom_b_mem [4];

    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    sccb_init_sequencer #(.AW(5), .DEV_ADDR(8'h42), .DELAY_UNIT(10), .MAX_RETRY(3)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .sccb_req(req_a), .sccb_ready(sccb_ready), .sccb_dev(dev_a),
        .sccb_reg(reg_a), .sccb_data(data_a),
        .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .busy(busy_a), .cfg_done(cdone_a), .cfg_err(cerr_a)
    );

    sccb_init_sequencer #(.AW(2), .DEV_ADDR(8'h42), .DELAY_UNIT(10), .MAX_RETRY(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .sccb_req(req_b), .sccb_ready(sccb_ready), .sccb_dev(dev_b),
        .sccb_reg(reg_b), .sccb_data(data_b),
        .sccb_done(sccb_done), .sccb_nack(sccb_nack),
        .busy(busy_b), .cfg_done(cdone_b), .cfg_err(cerr_b)
    );

    // Synchronous ROMs: data follows the address by one clock.
    always @(posedge clk) begin
        rom_data_a <= rom_a_mem[rom_addr_a];
        rom_data_b <= rom_b_mem[rom_addr_b];
    end

    logic       m_req;
    logic [7:0] m_reg, m_data;
    assign m_req  = sel ? req_b  : req_a;
    assign m_reg  = sel ? reg_b  : reg_a;
    assign m_data = sel ? data_b : data_a;

    // SCCB master model, evaluated on the falling edge. It logs every accepted
    // request and answers with a done pulse 5 clocks after acceptance.
    logic [15:0] log_q [$];
    int          acc_cyc [$];
    int          done_cyc [$];
    int          cyc = 0;
    int          m_cnt = 0;
    int          n_done = 0;
    int          nack_until = 0;
    logic        always_nack = 1'b0;

    always @(negedge clk) begin
        cyc++;
        sccb_done = 1'b0;
        sccb_nack = 1'b0;
        if (reset) begin
            m_cnt = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    sccb_done = 1'b1;
                    sccb_nack = always_nack || (n_done < nack_until);
                    n_done++;
                    done_cyc.push_back(cyc);
                end
            end
            if (m_req && sccb_ready) begin
                log_q.push_back({m_reg, m_data});
                acc_cyc.push_back(cyc);
                m_cnt = 5;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic pulse_b();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && (sel ? busy_b : busy_a); i++) tick();
        check(tag, 32'(sel ? busy_b : busy_a), 32'd0);
    endtask

    task automatic clear_rom_a();
        for (int i = 0; i < 32; i++) rom_a_mem[i] = 16'hFFFF;
    endtask

    int   base;
    int   gap;
    logic stable;

    initial begin
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
        sccb_ready = 1'b1; sel = 1'b0;
        clear_rom_a();
        for (int i = 0; i < 4; i++) rom_b_mem[i] = 16'hFFFF;
        ticks(3);

        // Reset values
        check("rst_req",   32'(req_a),      32'd0);
        check("rst_busy",  32'(busy_a),     32'd0);
        check("rst_addr",  32'(rom_addr_a), 32'd0);
        check("rst_reg",   32'(reg_a),      32'd0);
        check("rst_data",  32'(data_a),     32'd0);
        check("rst_done",  32'(cdone_a),    32'd0);
        check("rst_err",   32'(cerr_a),     32'd0);
        check("rst_dev",   32'(dev_a),      32'h42);
        reset = 1'b0;
        ticks(2);

        // T1: write, delay marker, write, end marker
        rom_a_mem[0] = 16'h1280; rom_a_mem[1] = 16'hFE01;
        rom_a_mem[2] = 16'h1101; rom_a_mem[3] = 16'hFFFF;
        base = log_q.size();
        pulse_a();                                // now in FETCH
        check("t1_busy",     32'(busy_a), 32'd1);
        check("t1_lat_fetch", 32'(req_a), 32'd0);
        tick();                                   // DECODE
        check("t1_lat_dec",  32'(req_a),  32'd0);
        tick();                                   // ISSUE
        check("t1_lat_req",  32'(req_a),  32'd1);
        wait_idle("t1_timeout", 400);
        check("t1_count", 32'(log_q.size() - base), 32'd2);
        check("t1_w0",    32'(log_q[base]),         32'h1280);
        check("t1_w1",    32'(log_q[base+1]),       32'h1101);
        gap = acc_cyc[base+1] - done_cyc[base];
        check("t1_gap_ge10", 32'(gap >= 10),        32'd1);
        check("t1_cfg_done", 32'(cdone_a),          32'd1);
        check("t1_cfg_err",  32'(cerr_a),           32'd0);

        // T2: 20-cycle stall in ISSUE, with a start pulse that must be ignored
        clear_rom_a();
        rom_a_mem[0] = 16'h5566;
        sccb_ready = 1'b0;
        base = log_q.size();
        pulse_a();
        for (int i = 0; i < 20 && !req_a; i++) tick();
        check("t2_req_up", 32'(req_a), 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) pulse_a(); else tick();
            stable &= (req_a === 1'b1) && (reg_a === 8'h55) && (data_a === 8'h66);
        end
        check("t2_stable",    32'(stable),              32'd1);
        check("t2_no_accept", 32'(log_q.size() - base), 32'd0);
        check("t2_addr_hold", 32'(rom_addr_a),          32'd0);
        sccb_ready = 1'b1;
        wait_idle("t2_timeout", 100);
        check("t2_count", 32'(log_q.size() - base), 32'd1);
        check("t2_w0",    32'(log_q[base]),         32'h5566);
        check("t2_done",  32'(cdone_a),             32'd1);

        // T3: two NACKs then ACK
        clear_rom_a();
        rom_a_mem[0] = 16'h3A04; rom_a_mem[1] = 16'h1122;
        base = log_q.size();
        nack_until = n_done + 2;
        pulse_a();
        wait_idle("t3_timeout", 300);
        check("t3_count", 32'(log_q.size() - base), 32'd4);
        check("t3_w0",    32'(log_q[base]),         32'h3A04);
        check("t3_w1",    32'(log_q[base+1]),       32'h3A04);
        check("t3_w2",    32'(log_q[base+2]),       32'h3A04);
        check("t3_w3",    32'(log_q[base+3]),       32'h1122);
        check("t3_done",  32'(cdone_a),             32'd1);
        check("t3_err",   32'(cerr_a),              32'd0);

        // T4: permanent NACK exhausts the retry budget
        base = log_q.size();
        always_nack = 1'b1;
        pulse_a();
        wait_idle("t4_timeout", 300);
        check("t4_count", 32'(log_q.size() - base), 32'd4);
        check("t4_w3",    32'(log_q[base+3]),       32'h3A04);
        check("t4_err",   32'(cerr_a),              32'd1);
        check("t4_done",  32'(cdone_a),             32'd0);
        ticks(10);
        always_nack = 1'b0;
        check("t4_addr_stuck", 32'(rom_addr_a),          32'd0);
        check("t4_no_more",    32'(log_q.size() - base), 32'd4);
        check("t4_idle",       32'(busy_a),              32'd0);

        // T5: AW=2 table filled with writes, no end marker
        sel = 1'b1;
        rom_b_mem[0] = 16'h0102; rom_b_mem[1] = 16'h0304;
        rom_b_mem[2] = 16'h0506; rom_b_mem[3] = 16'h0708;
        base = log_q.size();
        pulse_b();
        wait_idle("t5_timeout", 300);
        check("t5_count", 32'(log_q.size() - base), 32'd4);
        check("t5_w0",    32'(log_q[base]),         32'h0102);
        check("t5_w3",    32'(log_q[base+3]),       32'h0708);
        check("t5_addr",  32'(rom_addr_b),          32'd3);
        check("t5_done",  32'(cdone_b),             32'd1);
        ticks(10);
        check("t5_no_wrap", 32'(log_q.size() - base), 32'd4);
        sel = 1'b0;

        // T6: reset while waiting for sccb_done, then a clean restart
        clear_rom_a();
        rom_a_mem[0] = 16'h1280; rom_a_mem[1] = 16'h1101;
        base = log_q.size();
        pulse_a();
        for (int i = 0; i < 20 && log_q.size() == base; i++) tick();
        tick();
        check("t6_in_wait", 32'(busy_a && !req_a), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_rst_req",  32'(req_a),  32'd0);
        check("t6_rst_busy", 32'(busy_a), 32'd0);
        tick();
        reset = 1'b0;
        ticks(10);
        check("t6_idle", 32'(busy_a), 32'd0);
        base = log_q.size();
        pulse_a();
        check("t6_restart_addr", 32'(rom_addr_a), 32'd0);
        wait_idle("t6_timeout", 300);
        check("t6_count", 32'(log_q.size() - base), 32'd2);
        check("t6_w0",    32'(log_q[base]),         32'h1280);
        check("t6_w1",    32'(log_q[base+1]),       32'h1101);
        check("t6_done",  32'(cdone_a),             32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
